// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults and helpers for the UART receive FIFO slice.
package uart_rx_fifo_pkg;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_IRQ_LEVEL = 1;

    // Per-cycle control decisions derived from the strobes and the current fill level.
    typedef struct packed {
        logic push;
        logic pop;
        logic wr_ok;
        logic ovr_set;
    } fifo_ctl_t;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int level_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side write strobe, consumer-side read handshake and status of the RX FIFO.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int DEPTH     = DEF_DEPTH
);
    localparam int LW = level_bits(DEPTH);

    logic                 RX_DRDY;
    logic [DATA_BITS-1:0] RX_DI;
    logic                 RD_EN;
    logic                 OVR_CLR;
    logic [DATA_BITS-1:0] RD_DO;
    logic                 RD_VALID;
    logic                 EMPTY;
    logic                 FULL;
    logic [LW-1:0]        LEVEL;
    logic                 OVERRUN;
    logic                 RX_IRQ;

    modport master (
        output RX_DRDY, RX_DI, RD_EN, OVR_CLR,
        input  RD_DO, RD_VALID, EMPTY, FULL, LEVEL, OVERRUN, RX_IRQ
    );

    modport slave (
        input  RX_DRDY, RX_DI, RD_EN, OVR_CLR,
        output RD_DO, RD_VALID, EMPTY, FULL, LEVEL, OVERRUN, RX_IRQ
    );

endinterface

// File: rtl/uart_rx_fifo_ram.sv
// DEPTH x DATA_BITS storage: one synchronous write port, one synchronous read port
// whose output register doubles as the popped-character register.
module uart_rx_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AW        = ptr_bits(DEF_DEPTH)
) (
    input  logic                 CLK,
    input  logic                 NRST,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [DATA_BITS-1:0] rd_data_r;

    // Storage write; contents survive reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register: old contents are returned when the same slot is written this cycle.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            rd_data_r <= {DATA_BITS{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detected capture into a circular FIFO,
// explicit level counter, sticky overrun flag and level-threshold interrupt.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int IRQ_LEVEL = DEF_IRQ_LEVEL
) (
    input  logic           CLK,
    input  logic           NRST,
    uart_rx_fifo_if.slave  bus
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int LW = level_bits(DEPTH);

    logic                 drdy_q_r;
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [LW-1:0]        level_r;
    logic                 rd_valid_r;
    logic                 overrun_r;
    fifo_ctl_t            ctl_s;
    logic                 empty_s;
    logic                 full_s;
    logic                 irq_s;
    logic [DATA_BITS-1:0] rd_do_s;

    // Level decode and push/pop/overrun decisions for this cycle.
    always_comb begin
        empty_s       = (level_r == {LW{1'b0}});
        full_s        = (level_r == LW'(DEPTH));
        irq_s         = (level_r >= LW'(IRQ_LEVEL));
        ctl_s.push    = bus.RX_DRDY & ~drdy_q_r;
        ctl_s.pop     = bus.RD_EN & ~empty_s;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        ctl_s.wr_ok   = ctl_s.push & (~full_s | ctl_s.pop);
        ctl_s.ovr_set = ctl_s.push & full_s & ~ctl_s.pop;
    end

    // Pointers, level counter, read strobe and sticky overrun.
    always_ff @(posedge CLK) begin
        if (!NRST) begin
            drdy_q_r   <= 1'b0;
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            level_r    <= {LW{1'b0}};
            rd_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            drdy_q_r   <= bus.RX_DRDY;
            rd_valid_r <= ctl_s.pop;
            if (ctl_s.wr_ok) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (ctl_s.pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({ctl_s.wr_ok, ctl_s.pop})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            // A fresh overrun outranks a clear issued in the same cycle.
            if (ctl_s.ovr_set) begin
                overrun_r <= 1'b1;
            end else if (bus.OVR_CLR) begin
                overrun_r <= 1'b0;
            end
        end
    end

    uart_rx_fifo_ram #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .AW        (PW)
    ) u_ram (
        .CLK     (CLK),
        .NRST    (NRST),
        .wr_en   (ctl_s.wr_ok),
        .wr_addr (wr_ptr_r),
        .wr_data (bus.RX_DI),
        .rd_en   (ctl_s.pop),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_do_s)
    );

    assign bus.RD_DO    = rd_do_s;
    assign bus.RD_VALID = rd_valid_r;
    assign bus.EMPTY    = empty_s;
    assign bus.FULL     = full_s;
    assign bus.LEVEL    = level_r;
    assign bus.OVERRUN  = overrun_r;
    assign bus.RX_IRQ   = irq_s;

endmodule
